// File: rtl/operand_fetch.sv
// operand_fetch: sequences ra/rb reads through a single registered RF port, bypasses writeback into held operands
module operand_fetch #(
    parameter int addr_width = 4,
    parameter int data_width = 16,
    parameter int tag_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [addr_width-1:0] in_ra,
    input  logic [addr_width-1:0] in_rb,
    input  logic [addr_width-1:0] in_rd,
    input  logic                  in_use_b,
    input  logic [data_width-1:0] in_imm,
    input  logic [tag_width-1:0]  in_tag,
    output logic [addr_width-1:0] rf_radr,
    input  logic [data_width-1:0] rf_dout,
    input  logic                  wb_we,
    input  logic [addr_width-1:0] wb_wadr,
    input  logic [data_width-1:0] wb_din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_a,
    output logic [data_width-1:0] out_b,
    output logic [addr_width-1:0] out_rd,
    output logic [tag_width-1:0]  out_tag
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, VALID} state_t;
    state_t state;
    logic [addr_width-1:0] ra, rb, rd;
    logic use_b;
    logic [data_width-1:0] imm, a, b;
    logic [tag_width-1:0] tag;
    logic hit_a, hit_b, accept;
    assign hit_a = wb_we && wb_wadr == ra;
    assign hit_b = wb_we && wb_wadr == rb;
    assign in_ready = state == IDLE || (state == VALID && out_ready);
    assign accept = in_valid && in_ready;
    assign rf_radr = state == RD_A ? ra : rb;
    assign out_a = a;
    assign out_b = b;
    assign out_rd = rd;
    assign out_tag = tag;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out_valid <= 1'b0;
            ra <= '0;
            rb <= '0;
            rd <= '0;
            use_b <= 1'b0;
            imm <= '0;
            tag <= '0;
            a <= '0;
            b <= '0;
        end else begin
            if (accept) begin
                ra <= in_ra;
                rb <= in_rb;
                rd <= in_rd;
                use_b <= in_use_b;
                imm <= in_imm;
                tag <= in_tag;
            end
            case (state)
                IDLE: state <= accept ? RD_A : IDLE;
                RD_A: state <= RD_B;
                RD_B: begin
                    a <= hit_a ? wb_din : rf_dout;
                    state <= CAP;
                end
                CAP: begin
                    b <= use_b ? (hit_b ? wb_din : rf_dout) : imm;
                    if (hit_a) a <= wb_din;
                    out_valid <= 1'b1;
                    state <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state <= accept ? RD_A : IDLE;
                    end else begin
                        // held operands keep tracking writeback to their source registers
                        if (hit_a) a <= wb_din;
                        if (use_b && hit_b) b <= wb_din;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: vector table plus hazard, stall, back-to-back and reset sequences against a write-first RF model
module tb_operand_fetch;
    logic clk, reset, in_valid, in_ready, in_use_b, wb_we, out_valid, out_ready;
    logic [3:0] in_ra, in_rb, in_rd, rf_radr, wb_wadr, out_rd;
    logic [15:0] in_imm, rf_dout, wb_din, out_a, out_b;
    logic [7:0] in_tag, out_tag;
    logic [15:0] mem [16];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] ra, rb, rd;
        logic ub;
        logic [15:0] imm;
        logic [7:0] tag;
        int wc;
        logic [3:0] wa;
        logic [15:0] wv, ea, eb;
    } vec_t;
    typedef struct {
        logic [15:0] a, b;
        logic [3:0] rd;
        logic [7:0] tag;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[10];
    vec_t stl[3];

    operand_fetch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_use_b(in_use_b),
        .in_imm(in_imm), .in_tag(in_tag), .rf_radr(rf_radr), .rf_dout(rf_dout),
        .wb_we(wb_we), .wb_wadr(wb_wadr), .wb_din(wb_din),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_tag(out_tag)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // write-first register file: a write in the read cycle is visible in the read data
    always @(posedge clk) begin
        if (wb_we) mem[wb_wadr] <= wb_din;
        rf_dout <= (wb_we && wb_wadr == rf_radr) ? wb_din : mem[rf_radr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got a=%h b=%h expected no transfer", out_a, out_b);
            end else begin
                e = sb.pop_front();
                chk("sb_out_a", out_a, e.a);
                chk("sb_out_b", out_b, e.b);
                chk("sb_out_rd", out_rd, e.rd);
                chk("sb_out_tag", out_tag, e.tag);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_ra = v.ra; in_rb = v.rb; in_rd = v.rd;
        in_use_b = v.ub; in_imm = v.imm; in_tag = v.tag;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] v);
        wb_we = 1; wb_wadr = a; wb_din = v;
        step;
        wb_we = 0;
    endtask

    task automatic run(input vec_t v, input bit stall);
        out_ready = !stall;
        drive(v);
        in_valid = 1;
        chk("in_ready_idle", in_ready, 1);
        sb.push_back('{v.ea, v.eb, v.rd, v.tag});
        step;
        in_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            chk("out_valid_low", out_valid, 0);
            chk("rf_radr", rf_radr, c == 1 ? v.ra : v.rb);
            wb_we = !stall && v.wc == c; wb_wadr = v.wa; wb_din = v.wv;
            step;
        end
        wb_we = 0;
        chk("out_valid_high", out_valid, 1);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_rd", out_rd, v.rd);
                chk("stall_tag", out_tag, v.tag);
                wb_we = k == 1; wb_wadr = v.wa; wb_din = v.wv;
                step;
            end
            wb_we = 0;
            chk("stall_a", out_a, v.ea);
            chk("stall_b", out_b, v.eb);
            out_ready = 1;
        end
        step;
        chk("out_valid_after", out_valid, 0);
    endtask

    task automatic chk_reset_state;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_rf_radr", rf_radr, 0);
    endtask

    initial begin
        vec_t i1, i2, r;
        //            ra rb rd ub imm       tag   wc wa  wv        ea        eb
        tbl[0] = '{4'h3, 4'h5, 4'h7, 1, 16'h0, 8'hA5, 0, 4'h0, 16'h0, 16'h1234, 16'h00FF};
        tbl[1] = '{4'h2, 4'h9, 4'h1, 0, 16'hBEEF, 8'h3C, 3, 4'h9, 16'hCAFE, 16'h0001, 16'hBEEF};
        tbl[2] = '{4'h5, 4'h3, 4'h4, 1, 16'h0, 8'h11, 0, 4'h0, 16'h0, 16'h00FF, 16'h1234};
        tbl[3] = '{4'h3, 4'h3, 4'h2, 1, 16'h0, 8'h22, 0, 4'h0, 16'h0, 16'h1234, 16'h1234};
        tbl[4] = '{4'h3, 4'h5, 4'h6, 1, 16'h0, 8'h33, 1, 4'h3, 16'h5555, 16'h5555, 16'h00FF};
        tbl[5] = '{4'h3, 4'h5, 4'h6, 1, 16'h0, 8'h34, 2, 4'h3, 16'h6666, 16'h6666, 16'h00FF};
        tbl[6] = '{4'h3, 4'h5, 4'h6, 1, 16'h0, 8'h35, 3, 4'h5, 16'h7777, 16'h6666, 16'h7777};
        tbl[7] = '{4'h1, 4'h4, 4'hF, 1, 16'h0, 8'hFF, 1, 4'h4, 16'h1111, 16'hA0A0, 16'h1111};
        tbl[8] = '{4'h4, 4'h1, 4'h0, 1, 16'h0, 8'h01, 3, 4'h4, 16'h2222, 16'h2222, 16'hA0A0};
        tbl[9] = '{4'h9, 4'h2, 4'h8, 0, 16'h0000, 8'h00, 2, 4'h9, 16'h0F0F, 16'h0F0F, 16'h0000};
        stl[0] = '{4'h3, 4'h5, 4'h8, 1, 16'h0, 8'h40, 0, 4'h3, 16'h9999, 16'h9999, 16'h7777};
        stl[1] = '{4'h3, 4'h3, 4'h9, 1, 16'h0, 8'h41, 0, 4'h3, 16'hABCD, 16'hABCD, 16'hABCD};
        stl[2] = '{4'h2, 4'h5, 4'hA, 0, 16'hBEEF, 8'h42, 0, 4'h5, 16'h1357, 16'h0001, 16'hBEEF};
        reset = 1; in_valid = 0; out_ready = 0; wb_we = 0; wb_wadr = 0; wb_din = 0;
        in_ra = 0; in_rb = 0; in_rd = 0; in_use_b = 0; in_imm = 0; in_tag = 0;
        step;
        step;
        reset = 0;
        chk_reset_state();
        wr(4'h1, 16'hA0A0);
        wr(4'h2, 16'h0001);
        wr(4'h3, 16'h1234);
        wr(4'h4, 16'h4444);
        wr(4'h5, 16'h00FF);
        wr(4'h9, 16'h0909);
        foreach (tbl[i]) run(tbl[i], 0);
        foreach (stl[i]) run(stl[i], 1);
        // back-to-back with in_valid held; regs now r1=A0A0 r2=0001 r4=2222 r9=0F0F
        i1 = '{4'h1, 4'h2, 4'h3, 1, 16'h0, 8'h50, 0, 4'h0, 16'h0, 16'hA0A0, 16'h0001};
        i2 = '{4'h4, 4'h9, 4'h5, 1, 16'h0, 8'h51, 0, 4'h0, 16'h0, 16'h2222, 16'h0F0F};
        out_ready = 1;
        drive(i1);
        in_valid = 1;
        sb.push_back('{i1.ea, i1.eb, i1.rd, i1.tag});
        sb.push_back('{i2.ea, i2.eb, i2.rd, i2.tag});
        step;
        drive(i2);
        chk("b2b_busy_not_ready", in_ready, 0);
        step;
        step;
        step;
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_ready_in_valid", in_ready, 1);
        step;
        in_valid = 0;
        chk("b2b_gap_valid", out_valid, 0);
        chk("b2b_rd_a_radr", rf_radr, 4'h4);
        step;
        step;
        chk("b2b_early_valid", out_valid, 0);
        step;
        chk("b2b_second_valid", out_valid, 1);
        step;
        chk("b2b_done", out_valid, 0);
        // reset during RD_B drops the instruction
        r = '{4'h3, 4'h5, 4'h7, 1, 16'h0, 8'h77, 0, 4'h0, 16'h0, 16'h0, 16'h0};
        drive(r);
        in_valid = 1;
        step;
        in_valid = 0;
        step;
        chk("pre_reset_radr", rf_radr, 4'h5);
        reset = 1;
        step;
        reset = 0;
        chk_reset_state();
        step;
        chk("post_reset_idle", out_valid, 0);
        r = '{4'h5, 4'h3, 4'hB, 1, 16'h0, 8'h60, 0, 4'h0, 16'h0, 16'h1357, 16'hABCD};
        run(r, 0);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
